unpack_pipe: RTL and testbench

- Two-stage, valid/ready pipelined operand unpacker placed directly ahead of the FPU add/mul datapaths.
- Splits a packed single or double operand into sign, unbiased signed exponent, normalized 53-bit significand, leading-zero count and class flags.
- Denormals are fully normalized, with the exponent adjusted by the leading-zero count.
- Single operands occupy x[63:32], matching the existing significand unpacker layout.

---
 rtl/fpu_unpack_pkg.sv | 19 +
 rtl/cls.sv | 21 ++
 rtl/leadingzero.sv | 27 ++
 rtl/unpack_classify.sv | 49 ++++
 rtl/unpack_pipe.sv | 168 ++++++++++++++++
 tb/tb_unpack_pipe.sv | 285 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fpu_unpack_pkg.sv
// rtl/fpu_unpack_pkg.sv - shared constants and class-flag type for the operand unpacker
package fpu_unpack_pkg;

   localparam int DBL_BIAS = 1023;
   localparam int SGL_BIAS = 127;
   localparam int DBL_EW   = 11;
   localparam int SGL_EW   = 8;
   localparam int FW       = 53;
   localparam int LZ_ZERO  = 53;

   typedef struct packed {
      logic snan;
      logic qnan;
      logic inf;
      logic denorm;
      logic zero;
   } cls_t;

endpackage

// File: rtl/cls.sv
// rtl/cls.sv - logarithmic left shifter used to normalize the significand
module cls #(
   parameter int u = 53,
   parameter int s = 6
) (
   input  logic [u-1:0] a_i,
   input  logic [s-1:0] sh_i,
   output logic [u-1:0] y_o
);

   logic [u-1:0] stage [s+1];

   assign stage[0] = a_i;

   for (genvar k = 0; k < s; k++) begin : g_stage
      assign stage[k+1] = sh_i[k] ? (stage[k] << (1 << k)) : stage[k];
   end

   assign y_o = stage[s];

endmodule

// File: rtl/leadingzero.sv
// rtl/leadingzero.sv - leading-zero counter, MSB first
module leadingzero #(
   parameter int n = 64,
   parameter int m = 6
) (
   input  logic [n-1:0] a_i,
   output logic [m-1:0] cnt_o
);

   logic found;

   // Callers guarantee a set bit somewhere, so the count never wraps.
   always_comb begin
      cnt_o = '0;
      found = 1'b0;
      for (int i = n - 1; i >= 0; i--) begin
         if (!found) begin
            if (a_i[i]) begin
               found = 1'b1;
            end else begin
               cnt_o = cnt_o + m'(1);
            end
         end
      end
   end

endmodule

// File: rtl/unpack_classify.sv
// rtl/unpack_classify.sv - field split, biased exponent removal and class flags
module unpack_classify
   import fpu_unpack_pkg::*;
#(
   parameter int N  = 64,
   parameter int EW = 13
) (
   input  logic                 db_i,
   input  logic [N-1:0]         x_i,
   output logic                 sign_o,
   output logic [FW-1:0]        te_o,
   output logic signed [EW-1:0] exp_o,
   output cls_t                 cls_o
);

   logic [DBL_EW-1:0]    e;
   logic [FW-2:0]        f;
   logic                 ez;
   logic                 emax;
   logic                 fz;
   logic signed [EW-1:0] bias;

   // Single operands live in the upper word; their fraction is left-aligned into F.
   always_comb begin
      if (db_i) begin
         e    = x_i[62:52];
         f    = x_i[51:0];
         emax = &x_i[62:52];
         bias = EW'(DBL_BIAS);
      end else begin
         e    = {{(DBL_EW - SGL_EW){1'b0}}, x_i[62:55]};
         f    = {x_i[54:32], 29'b0};
         emax = &x_i[62:55];
         bias = EW'(SGL_BIAS);
      end
      ez     = (e == '0);
      fz     = (f == '0);
      sign_o = x_i[N-1];
      te_o   = {~ez, f};
      exp_o  = $signed({{(EW - DBL_EW){1'b0}}, e}) - bias;

      cls_o.zero   = ez && fz;
      cls_o.denorm = ez && !fz;
      cls_o.inf    = emax && fz;
      cls_o.qnan   = emax && f[FW-2];
      cls_o.snan   = emax && !f[FW-2] && !fz;
   end

endmodule

// File: rtl/unpack_pipe.sv
// rtl/unpack_pipe.sv - two-stage valid/ready operand unpacker feeding the FPU datapaths
module unpack_pipe
   import fpu_unpack_pkg::*;
#(
   parameter int N  = 64,
   parameter int EW = 13
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          db,
   input  logic [N-1:0]  x,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          sign_o,
   output logic [EW-1:0] exp_o,
   output logic [FW-1:0] f_o,
   output logic [5:0]    lz_o,
   output logic [4:0]    cls_o
);

   logic                 c_sign;
   logic [FW-1:0]        c_te;
   logic signed [EW-1:0] c_exp;
   cls_t                 c_cls;
   logic [5:0]           c_lz_raw;
   logic [5:0]           c_lz;

   logic                 v1_q, v1_d;
   logic                 sign1_q, sign1_d;
   logic [FW-1:0]        te1_q, te1_d;
   logic signed [EW-1:0] exp1_q, exp1_d;
   logic [5:0]           lz1_q, lz1_d;
   cls_t                 cls1_q, cls1_d;

   logic                 v2_q, v2_d;
   logic                 sign_q, sign_d;
   logic signed [EW-1:0] exp_q, exp_d;
   logic [FW-1:0]        f_q, f_d;
   logic [5:0]           lz_q, lz_d;
   cls_t                 cls_q, cls_d;

   logic                 ld1;
   logic                 ld2;
   logic                 special;
   logic [5:0]           sh;
   logic [FW-1:0]        f_sh;

   unpack_classify #(.N(N), .EW(EW)) u_classify (
      .db_i   (db),
      .x_i    (x),
      .sign_o (c_sign),
      .te_o   (c_te),
      .exp_o  (c_exp),
      .cls_o  (c_cls)
   );

   // Trailing ones bound the count at 53 when the significand is all zero.
   leadingzero #(.n(64), .m(6)) u_lz (
      .a_i   ({c_te, {(N - FW){1'b1}}}),
      .cnt_o (c_lz_raw)
   );

   assign c_lz = (c_lz_raw > 6'(LZ_ZERO)) ? 6'(LZ_ZERO) : c_lz_raw;

   assign ld2      = !v2_q || out_ready;
   assign ld1      = !v1_q || ld2;
   assign in_ready = ld1;

   assign special = cls1_q.inf || cls1_q.qnan || cls1_q.snan;
   assign sh      = special ? 6'd0 : lz1_q;

   cls #(.u(FW), .s(6)) u_shift (
      .a_i  (te1_q),
      .sh_i (sh),
      .y_o  (f_sh)
   );

   always_comb begin
      v1_d    = v1_q;
      sign1_d = sign1_q;
      te1_d   = te1_q;
      exp1_d  = exp1_q;
      lz1_d   = lz1_q;
      cls1_d  = cls1_q;
      if (ld1) begin
         v1_d = in_valid;
         if (in_valid) begin
            sign1_d = c_sign;
            te1_d   = c_te;
            exp1_d  = c_exp;
            lz1_d   = c_lz;
            cls1_d  = c_cls;
         end
      end

      v2_d   = v2_q;
      sign_d = sign_q;
      exp_d  = exp_q;
      f_d    = f_q;
      lz_d   = lz_q;
      cls_d  = cls_q;
      // Output registers only change on a real load, so they hold while stalled.
      if (ld2) begin
         v2_d = v1_q;
         if (v1_q) begin
            sign_d = sign1_q;
            cls_d  = cls1_q;
            if (cls1_q.zero) begin
               f_d   = '0;
               exp_d = '0;
               lz_d  = 6'(LZ_ZERO);
            end else if (special) begin
               f_d   = f_sh;
               exp_d = exp1_q;
               lz_d  = 6'd0;
            end else if (cls1_q.denorm) begin
               f_d   = f_sh;
               exp_d = exp1_q + EW'(1) - $signed({{(EW - 6){1'b0}}, lz1_q});
               lz_d  = lz1_q;
            end else begin
               f_d   = f_sh;
               exp_d = exp1_q;
               lz_d  = lz1_q;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q    <= 1'b0;
         sign1_q <= 1'b0;
         te1_q   <= '0;
         exp1_q  <= '0;
         lz1_q   <= '0;
         cls1_q  <= '0;
         v2_q    <= 1'b0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         f_q     <= '0;
         lz_q    <= '0;
         cls_q   <= '0;
      end else begin
         v1_q    <= v1_d;
         sign1_q <= sign1_d;
         te1_q   <= te1_d;
         exp1_q  <= exp1_d;
         lz1_q   <= lz1_d;
         cls1_q  <= cls1_d;
         v2_q    <= v2_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         f_q     <= f_d;
         lz_q    <= lz_d;
         cls_q   <= cls_d;
      end
   end

   assign out_valid = v2_q;
   assign sign_o    = sign_q;
   assign exp_o     = exp_q;
   assign f_o       = f_q;
   assign lz_o      = lz_q;
   assign cls_o     = cls_q;

endmodule

// File: tb/tb_unpack_pipe.sv
// tb/tb_unpack_pipe.sv - randomized scoreboard bench for unpack_pipe
module tb_unpack_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        db;
   logic [63:0] x;
   logic        out_valid;
   logic        out_ready;
   logic        sign_o;
   logic [12:0] exp_o;
   logic [52:0] f_o;
   logic [5:0]  lz_o;
   logic [4:0]  cls_o;

   unpack_pipe #(.N(64), .EW(13)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .db        (db),
      .x         (x),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sign_o    (sign_o),
      .exp_o     (exp_o),
      .f_o       (f_o),
      .lz_o      (lz_o),
      .cls_o     (cls_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        sign;
      int          e;
      logic [52:0] f;
      int          lz;
      logic [4:0]  c;
   } res_t;

   res_t expq[$];
   int   checks   = 0;
   int   failures = 0;
   bit   rand_mode = 1'b0;

   function automatic logic [77:0] mk(input logic s, input int e, input logic [52:0] f,
                                      input int lz, input logic [4:0] c);
      return {s, 13'(e), f, 6'(lz), c};
   endfunction

   function automatic logic [77:0] pack(input res_t r);
      return mk(r.sign, r.e, r.f, r.lz, r.c);
   endfunction

   // Reference: decode the IEEE fields directly and locate the top set fraction bit.
   function automatic res_t model(input logic d, input logic [63:0] v);
      res_t        r;
      int          ev, bias, emx, p;
      logic [51:0] fr;
      r.sign = v[63];
      if (d) begin
         ev = int'(v[62:52]); fr = v[51:0]; bias = 1023; emx = 2047;
      end else begin
         ev = int'(v[62:55]); fr = {v[54:32], 29'b0}; bias = 127; emx = 255;
      end
      if (ev == 0 && fr == 0) begin
         r.f = '0; r.e = 0; r.lz = 53; r.c = 5'b00001;
      end else if (ev == 0) begin
         p = 0;
         for (int i = 0; i < 52; i++) if (fr[i]) p = i;
         r.lz = 52 - p;
         r.f  = {1'b0, fr} << r.lz;
         r.e  = 1 - bias - r.lz;
         r.c  = 5'b00010;
      end else begin
         r.f = {1'b1, fr}; r.lz = 0; r.e = ev - bias;
         if (ev != emx)    r.c = 5'b00000;
         else if (fr == 0) r.c = 5'b00100;
         else if (fr[51])  r.c = 5'b01000;
         else              r.c = 5'b10000;
      end
      return r;
   endfunction

   task automatic check_vec(input string name, input logic [77:0] act, input logic [77:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [77:0] dut_vec();
      return {sign_o, exp_o, f_o, lz_o, cls_o};
   endfunction

   // Scoreboard and hold checker, sampled on the falling edge.
   initial begin
      logic        stall_prev;
      logic [77:0] prev_vec;
      res_t        r;
      stall_prev = 1'b0;
      prev_vec   = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            expq.delete();
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) check_vec("stall_hold", dut_vec(), prev_vec);
            if (out_valid && out_ready) begin
               if (expq.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL unexpected_output got=%h want=none", dut_vec());
               end else begin
                  r = expq.pop_front();
                  check_vec("result", dut_vec(), pack(r));
               end
            end
            if (in_valid && in_ready) expq.push_back(model(db, x));
            stall_prev = out_valid && !out_ready;
            prev_vec   = dut_vec();
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic push_op(input logic d, input logic [63:0] v);
      int   guard;
      logic ok;
      guard = 0;
      db = d; x = v; in_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = in_ready;
         step();
         guard++;
      end while (!ok && guard < 200);
      if (!ok) begin
         checks++; failures++;
         $display("FAIL push_timeout got=in_ready_0 want=in_ready_1");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      out_ready = 1'b1;
      while (expq.size() != 0 && guard < 100) begin
         step();
         guard++;
      end
      check_vec("drain_empty", 78'(expq.size()), 78'd0);
   endtask

   task automatic gen(output logic d, output logic [63:0] v);
      logic [63:0] rr;
      logic [51:0] fa;
      logic [10:0] e;
      int          kind;
      logic        s;
      d    = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 7);
      s    = 1'($urandom);
      rr   = {$urandom, $urandom};
      fa   = rr[51:0];
      case (kind)
         3:       fa = fa >> $urandom_range(0, 51);
         4, 5:    fa = '0;
         6:       fa[51] = 1'b1;
         7:       fa = fa >> $urandom_range(1, 51);
         default: ;
      endcase
      if (!d) fa[28:0] = '0;
      if ((kind == 3 || kind == 7) && fa == 0) begin
         if (d) fa[0] = 1'b1;
         else   fa[29] = 1'b1;
      end
      if (kind <= 2)      e = d ? 11'($urandom_range(1, 2046)) : 11'($urandom_range(1, 254));
      else if (kind <= 4) e = '0;
      else                e = d ? 11'h7FF : 11'h0FF;
      v = d ? {s, e, fa} : {s, e[7:0], fa[51:29], 32'($urandom)};
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        d;
      logic [63:0] v;
      rst = 1'b1; in_valid = 1'b0; db = 1'b0; x = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check_vec("reset_outputs", dut_vec(), 78'd0);
      check_vec("reset_out_valid", 78'(out_valid), 78'd0);
      check_vec("reset_in_ready", 78'(in_ready), 78'd1);

      check_vec("pin_one", pack(model(1'b1, 64'h3FF0000000000000)),
                mk(1'b0, 0, 53'h10000000000000, 0, 5'b00000));
      check_vec("pin_dbl_denorm", pack(model(1'b1, 64'h0000000000000001)),
                mk(1'b0, -1074, 53'h10000000000000, 52, 5'b00010));
      check_vec("pin_sgl_denorm", pack(model(1'b0, 64'h00000001DEADBEEF)),
                mk(1'b0, -149, 53'h10000000000000, 23, 5'b00010));
      check_vec("pin_sgl_negzero", pack(model(1'b0, 64'h8000000000000000)),
                mk(1'b1, 0, 53'h0, 53, 5'b00001));
      check_vec("pin_sgl_qnan", pack(model(1'b0, 64'h7FC0000000000000)),
                mk(1'b0, 128, 53'h18000000000000, 0, 5'b01000));
      check_vec("pin_dbl_snan", pack(model(1'b1, 64'h7FF0000000000001)),
                mk(1'b0, 1024, 53'h10000000000001, 0, 5'b10000));
      check_vec("pin_dbl_neginf", pack(model(1'b1, 64'hFFF0000000000000)),
                mk(1'b1, 1024, 53'h10000000000000, 0, 5'b00100));

      out_ready = 1'b1;
      push_op(1'b1, 64'h3FF0000000000000);
      @(negedge clk);
      check_vec("latency_cycle1", 78'(out_valid), 78'd0);
      @(negedge clk);
      check_vec("latency_cycle2", 78'(out_valid), 78'd1);
      @(posedge clk); #1;

      push_op(1'b1, 64'h0000000000000001);
      push_op(1'b0, 64'h00000001DEADBEEF);
      push_op(1'b0, 64'h8000000000000000);
      push_op(1'b0, 64'h7FC0000000000000);
      push_op(1'b1, 64'h7FF0000000000001);
      push_op(1'b1, 64'hFFF0000000000000);
      drain();

      out_ready = 1'b0;
      push_op(1'b1, 64'h4009_21FB_5444_2D18);
      push_op(1'b0, 64'hC2F6_E979_0000_0000);
      db = 1'b1; x = 64'h000F_FFFF_FFFF_FFFF; in_valid = 1'b1;
      @(negedge clk);
      check_vec("bp_in_ready_low", 78'(in_ready), 78'd0);
      check_vec("bp_out_valid", 78'(out_valid), 78'd1);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      out_ready = 1'b1;
      push_op(1'b1, 64'h000F_FFFF_FFFF_FFFF);
      push_op(1'b0, 64'h0040_0000_1234_5678);
      drain();

      out_ready = 1'b0;
      push_op(1'b1, 64'h3FF8000000000000);
      push_op(1'b0, 64'h3F80000000000000);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_vec("midrst_out_valid", 78'(out_valid), 78'd0);
      check_vec("midrst_outputs", dut_vec(), 78'd0);
      check_vec("midrst_in_ready", 78'(in_ready), 78'd1);
      out_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check_vec("midrst_no_stale", 78'(out_valid), 78'd0);
      end
      @(posedge clk); #1;

      rand_mode = 1'b1;
      for (int i = 0; i < 400; i++) begin
         gen(d, v);
         push_op(d, v);
         if ($urandom_range(0, 3) == 0) step();
      end
      rand_mode = 1'b0;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
